gpu_cmdserializer: RTL and testbench

//  Transmit side of the GP0 word stream that gpu_loadedRegs consumes.

---
 rtl/gpu_cmdserializer.sv | 213 +++++++++++++++++++++
 tb/tb_gpu_cmdserializer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmdserializer.sv
// GP0 command serializer: captures one primitive description and
// streams it out as 32-bit GP0 words over a valid/ready handshake.
module gpu_cmdserializer #(
  parameter bit ALLOW_RAW_TEX = 1'b1,
  parameter bit FILL_ALIGN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_command,
  input  logic [43:0] i_x,
  input  logic [43:0] i_y,
  input  logic [95:0] i_rgb,
  input  logic [63:0] i_uv,
  input  logic [15:0] i_clut,
  input  logic [15:0] i_tpage,
  input  logic [9:0]  i_width,
  input  logic [8:0]  i_height,
  output logic        o_validData,
  output logic [31:0] o_data,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_COLOR,
    S_VERTEX,
    S_UV,
    S_SIZE
  } state_t;

  state_t      state;
  state_t      nState;
  logic [1:0]  v;
  logic [1:0]  nV;
  logic        lastWord;
  logic [31:0] nWord;

  logic        startPoly;
  logic        startRect;
  logic        startFill;
  logic        startOk;
  logic [7:0]  cmdEff;

  logic [7:0]  cmdR;
  logic [10:0] xA   [4];
  logic [10:0] yA   [4];
  logic [23:0] rgbA [4];
  logic [15:0] uvA  [4];
  logic [15:0] clutR;
  logic [15:0] tpageR;
  logic [9:0]  widthR;
  logic [8:0]  heightR;
  logic        isPoly;
  logic        isFill;
  logic        gourR;
  logic        quadR;
  logic        texR;
  logic        sizeR;

  logic [10:0] vx;
  logic [10:0] vy;
  logic [15:0] hi16;
  logic [1:0]  lastV;

  assign startPoly = (i_command[7:5] == 3'b001);
  assign startRect = (i_command[7:5] == 3'b011);
  assign startFill = (i_command == 8'h02);
  assign startOk   = startPoly | startRect | startFill;
  assign cmdEff    = ALLOW_RAW_TEX ? i_command
                                   : {i_command[7:1], 1'b0};
  assign lastV     = quadR ? 2'd3 : 2'd2;

  // Latch the primitive description when a supported command starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmdR    <= 8'h00;
      clutR   <= 16'h0000;
      tpageR  <= 16'h0000;
      widthR  <= 10'd0;
      heightR <= 9'd0;
      isPoly  <= 1'b0;
      isFill  <= 1'b0;
      gourR   <= 1'b0;
      quadR   <= 1'b0;
      texR    <= 1'b0;
      sizeR   <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        xA[n]   <= 11'd0;
        yA[n]   <= 11'd0;
        rgbA[n] <= 24'd0;
        uvA[n]  <= 16'd0;
      end
    end else if (state == S_IDLE && i_start && startOk) begin
      cmdR    <= cmdEff;
      clutR   <= i_clut;
      tpageR  <= i_tpage;
      widthR  <= i_width;
      heightR <= i_height;
      isPoly  <= startPoly;
      isFill  <= startFill;
      gourR   <= startPoly & i_command[4];
      quadR   <= startPoly & i_command[3];
      texR    <= ~startFill & i_command[2];
      sizeR   <= startFill |
                 (startRect & (i_command[4:3] == 2'b00));
      for (int n = 0; n < 4; n++) begin
        xA[n]   <= i_x[11*n +: 11];
        yA[n]   <= i_y[11*n +: 11];
        rgbA[n] <= i_rgb[24*n +: 24];
        uvA[n]  <= i_uv[16*n +: 16];
      end
    end
  end

  // Successor word after the current one is accepted.
  always_comb begin
    nState   = state;
    nV       = v;
    lastWord = 1'b0;
    unique case (state)
      S_CMD: begin
        nState = S_VERTEX;
        nV     = 2'd0;
      end
      S_COLOR: nState = S_VERTEX;
      S_VERTEX, S_UV: begin
        if (state == S_VERTEX && texR) begin
          nState = S_UV;
        end else if (isPoly) begin
          if (v == lastV) begin
            lastWord = 1'b1;
          end else begin
            nV     = v + 2'd1;
            nState = gourR ? S_COLOR : S_VERTEX;
          end
        end else if (sizeR) begin
          nState = S_SIZE;
        end else begin
          lastWord = 1'b1;
        end
      end
      S_SIZE: lastWord = 1'b1;
      default: nState = S_IDLE;
    endcase
  end

  // Format the GP0 word for the successor state and vertex.
  always_comb begin
    vx = xA[nV];
    vy = yA[nV];
    if (FILL_ALIGN && isFill) vx[3:0] = 4'h0;
    hi16 = 16'h0000;
    if (nV == 2'd0) hi16 = clutR;
    else if (nV == 2'd1) hi16 = tpageR;
    nWord = 32'h0000_0000;
    unique case (nState)
      S_COLOR:  nWord = {8'h00, rgbA[nV]};
      S_VERTEX: nWord = {{5{vy[10]}}, vy, {5{vx[10]}}, vx};
      S_UV:     nWord = {hi16, uvA[nV]};
      S_SIZE:   nWord = {7'd0, heightR, 6'd0, widthR};
      S_CMD:    nWord = {cmdR, rgbA[0]};
      default:  nWord = 32'h0000_0000;
    endcase
  end

  // Sequencer with registered handshake and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      v           <= 2'd0;
      o_validData <= 1'b0;
      o_data      <= 32'h0000_0000;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;
      if (state == S_IDLE) begin
        if (i_start) begin
          if (startOk) begin
            state       <= S_CMD;
            v           <= 2'd0;
            o_validData <= 1'b1;
            o_busy      <= 1'b1;
            o_data      <= {cmdEff, i_rgb[23:0]};
          end else begin
            o_error <= 1'b1;
          end
        end
      end else if (o_validData && i_ready) begin
        if (lastWord) begin
          state       <= S_IDLE;
          v           <= 2'd0;
          o_validData <= 1'b0;
          o_busy      <= 1'b0;
          o_done      <= 1'b1;
          o_data      <= 32'h0000_0000;
        end else begin
          state  <= nState;
          v      <= nV;
          o_data <= nWord;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_cmdserializer.sv
// Bench for gpu_cmdserializer: queue-based word model plus
// directed literal checks and randomized handshake traffic.
module tb_gpu_cmdserializer;

  localparam bit ALLOW_RAW_TEX = 1'b1;
  localparam bit FILL_ALIGN    = 1'b1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_command;
  logic [43:0] i_x;
  logic [43:0] i_y;
  logic [95:0] i_rgb;
  logic [63:0] i_uv;
  logic [15:0] i_clut;
  logic [15:0] i_tpage;
  logic [9:0]  i_width;
  logic [8:0]  i_height;
  logic        o_validData;
  logic [31:0] o_data;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  always #5 i_clk = ~i_clk;

  gpu_cmdserializer #(
    .ALLOW_RAW_TEX(ALLOW_RAW_TEX),
    .FILL_ALIGN(FILL_ALIGN)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_command(i_command),
    .i_x(i_x),
    .i_y(i_y),
    .i_rgb(i_rgb),
    .i_uv(i_uv),
    .i_clut(i_clut),
    .i_tpage(i_tpage),
    .i_width(i_width),
    .i_height(i_height),
    .o_validData(o_validData),
    .o_data(o_data),
    .i_ready(i_ready),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_error(o_error)
  );

  logic [31:0] exp[$];
  logic [31:0] got[$];
  bit  mBusy;
  bit  expDone;
  bit  expErr;
  int  readyPct;
  int  passed;
  int  total;
  int  cyc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  task automatic chkBit(string name, logic act, logic req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b want %b", name, act, req);
  endtask

  task automatic chkInt(string name, int act, int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, req);
  endtask

  function automatic logic [31:0] vert(logic [10:0] x, logic [10:0] y);
    return {16'($signed(y)), 16'($signed(x))};
  endfunction

  // Expected GP0 word list for one primitive, straight from the word rules.
  function automatic void model();
    bit poly, rect, fill;
    logic [7:0]  c;
    logic [10:0] x0;
    logic [15:0] hi;
    int nv;
    c    = i_command;
    poly = (c[7:5] == 3'd1);
    rect = (c[7:5] == 3'd3);
    fill = (c == 8'h02);
    if (!(poly || rect || fill)) return;
    if (!ALLOW_RAW_TEX) c[0] = 1'b0;
    exp.push_back({c, i_rgb[23:0]});
    if (poly) begin
      nv = i_command[3] ? 4 : 3;
      for (int k = 0; k < nv; k++) begin
        if (i_command[4] && k > 0)
          exp.push_back({8'h00, i_rgb[24*k +: 24]});
        exp.push_back(vert(i_x[11*k +: 11], i_y[11*k +: 11]));
        if (i_command[2]) begin
          hi = (k == 0) ? i_clut : (k == 1) ? i_tpage : 16'h0000;
          exp.push_back({hi, i_uv[16*k +: 16]});
        end
      end
    end else begin
      x0 = i_x[10:0];
      if (fill && FILL_ALIGN) x0 = x0 & ~11'd15;
      exp.push_back(vert(x0, i_y[10:0]));
      if (rect && i_command[2]) exp.push_back({i_clut, i_uv[15:0]});
      if (fill || i_command[4:3] == 2'b00)
        exp.push_back({7'd0, i_height, 6'd0, i_width});
    end
  endfunction

  // One clock: update the model for this edge, then check at negedge.
  task automatic cycle();
    bit nDone;
    bit nErr;
    nDone = 0;
    nErr  = 0;
    if (mBusy && i_ready) begin
      got.push_back(o_data);
      void'(exp.pop_front());
      if (exp.size() == 0) begin
        mBusy = 0;
        nDone = 1;
      end
    end else if (!mBusy && i_start) begin
      model();
      if (exp.size() == 0) nErr = 1;
      else mBusy = 1;
    end
    @(negedge i_clk);
    cyc++;
    expDone = nDone;
    expErr  = nErr;
    chkBit("valid", o_validData, mBusy);
    chkBit("busy", o_busy, mBusy);
    chkBit("done", o_done, expDone);
    chkBit("error", o_error, expErr);
    if (mBusy) chk("data", o_data, exp[0]);
    i_start = 1'b0;
    i_ready = ($urandom_range(99) < readyPct);
  endtask

  task automatic randFields();
    int sel;
    sel = $urandom_range(3);
    case (sel)
      0: i_command = 8'h20 | 8'($urandom_range(31));
      1: i_command = 8'h60 | 8'($urandom_range(31));
      2: i_command = 8'h02;
      default: i_command = 8'($urandom);
    endcase
    i_x      = 44'({$urandom(), $urandom()});
    i_y      = 44'({$urandom(), $urandom()});
    i_rgb    = {$urandom(), $urandom(), $urandom()};
    i_uv     = {$urandom(), $urandom()};
    i_clut   = 16'($urandom);
    i_tpage  = 16'($urandom);
    i_width  = 10'($urandom);
    i_height = 9'($urandom);
  endtask

  // Start a primitive and run it to completion; optional ignored restart.
  task automatic runPrim(logic [7:0] c, int midStartAt);
    int n;
    got.delete();
    i_command = c;
    i_start   = 1'b1;
    cycle();
    n = 0;
    while (mBusy && n < 300) begin
      if (n == midStartAt) begin
        randFields();
        i_command = 8'h20;
        i_start   = 1'b1;
      end
      cycle();
      n++;
    end
    if (mBusy) chkBit("timeout", 1'b1, 1'b0);
  endtask

  task automatic midReset();
    #2 i_rst = 1'b1;
    #1;
    chkBit("rst_valid", o_validData, 1'b0);
    chkBit("rst_busy", o_busy, 1'b0);
    chkBit("rst_done", o_done, 1'b0);
    chk("rst_data", o_data, 32'h0);
    exp.delete();
    mBusy = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    passed   = 0;
    total    = 0;
    cyc      = 0;
    mBusy    = 0;
    readyPct = 100;
    i_rst    = 1'b1;
    i_start  = 1'b0;
    i_ready  = 1'b1;
    i_command = 8'h00;
    i_x = '0; i_y = '0; i_rgb = '0; i_uv = '0;
    i_clut = '0; i_tpage = '0; i_width = '0; i_height = '0;
    repeat (2) @(negedge i_clk);
    chkBit("reset_valid", o_validData, 1'b0);
    chkBit("reset_busy", o_busy, 1'b0);
    chkBit("reset_done", o_done, 1'b0);
    chkBit("reset_error", o_error, 1'b0);
    chk("reset_data", o_data, 32'h0);
    i_rst = 1'b0;
    cycle();

    // Flat triangle with hand-computed words.
    i_rgb = 96'h302010;
    i_x   = {11'd0, 11'h7FF, 11'd3, 11'd1};
    i_y   = {11'd0, 11'h7FE, 11'd4, 11'd2};
    runPrim(8'h20, -1);
    chkInt("tri_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("tri_w0", got[0], 32'h20302010);
      chk("tri_w1", got[1], 32'h00020001);
      chk("tri_w2", got[2], 32'h00040003);
      chk("tri_w3", got[3], 32'hFFFEFFFF);
    end

    // Gouraud textured quad: UV upper halves.
    randFields();
    runPrim(8'h3C, -1);
    chkInt("gtq_count", got.size(), 12);
    if (got.size() == 12) begin
      chk("gtq_uv0_hi", {16'h0, got[2][31:16]}, {16'h0, i_clut});
      chk("gtq_uv1_hi", {16'h0, got[5][31:16]}, {16'h0, i_tpage});
      chk("gtq_uv2_hi", {16'h0, got[8][31:16]}, 32'h0);
      chk("gtq_uv3_hi", {16'h0, got[11][31:16]}, 32'h0);
    end

    // Variable textured rect and fixed 16x16 rect.
    randFields();
    i_width  = 10'd300;
    i_height = 9'd200;
    runPrim(8'h64, -1);
    chkInt("vrect_count", got.size(), 4);
    if (got.size() == 4) chk("vrect_size", got[3], 32'h00C8012C);
    runPrim(8'h7C, -1);
    chkInt("rect16_count", got.size(), 3);

    // Fill with X alignment.
    i_x      = 44'h1F;
    i_y      = 44'd5;
    i_width  = 10'd33;
    i_height = 9'd7;
    runPrim(8'h02, -1);
    chkInt("fill_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("fill_vert", got[1], 32'h00050010);
      chk("fill_size", got[2], 32'h00070021);
    end

    // Stalling quad with an ignored restart mid-stream.
    readyPct = 50;
    randFields();
    runPrim(8'h3C, 5);
    chkInt("stall_count", got.size(), 12);

    // Unsupported command.
    readyPct = 100;
    runPrim(8'hE1, -1);
    chkInt("err_count", got.size(), 0);

    // Reset while word 5 of a quad is presented, then restart.
    randFields();
    got.delete();
    i_command = 8'h38;
    i_start   = 1'b1;
    cycle();
    n = 0;
    while (got.size() < 4 && n < 50) begin
      cycle();
      n++;
    end
    chkInt("pre_reset_words", got.size(), 4);
    midReset();
    cycle();
    i_rgb = 96'h302010;
    i_x   = {11'd0, 11'h7FF, 11'd3, 11'd1};
    i_y   = {11'd0, 11'h7FE, 11'd4, 11'd2};
    runPrim(8'h20, -1);
    chkInt("restart_count", got.size(), 4);
    if (got.size() == 4) chk("restart_w3", got[3], 32'hFFFEFFFF);

    // Randomized traffic with random stalls and stray starts.
    for (int p = 0; p < 40; p++) begin
      readyPct = 30 + $urandom_range(70);
      randFields();
      i_start = 1'b1;
      cycle();
      n = 0;
      while (mBusy && n < 300) begin
        if ($urandom_range(7) == 0) begin
          randFields();
          i_start = 1'b1;
        end
        cycle();
        n++;
      end
      if (mBusy) chkBit("rand_timeout", 1'b1, 1'b0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
